// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end with single-outstanding imem requests, skid buffer and branch redirect
module if_fetch #(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_ack_i,
  input  logic [INST_W-1:0] imem_data_i,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
  state_t            state;
  logic [ADDR_W-1:0] pc, redir, skid_pc;
  logic [INST_W-1:0] skid_inst;
  logic              ack, slot_free;
  // an ack only counts while a request is actually outstanding
  assign ack       = imem_req_o & imem_ack_i;
  assign slot_free = ~id_valid_o | ~stall_i;
  // fetch FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      redir       <= '0;
      skid_pc     <= '0;
      skid_inst   <= '0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
      id_valid_o  <= 1'b0;
      id_pc_o     <= '0;
      id_inst_o   <= '0;
    end else if (branch_i) begin
      id_valid_o <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= '0;
      if (imem_req_o && !imem_ack_i) begin
        redir <= branch_target_i;
        state <= DRAIN;
      end else begin
        pc          <= branch_target_i;
        imem_addr_o <= branch_target_i;
        imem_req_o  <= 1'b1;
        state       <= FETCH;
      end
    end else begin
      case (state)
        IDLE: begin
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc;
          state       <= FETCH;
        end
        FETCH: begin
          if (ack && slot_free) begin
            id_inst_o   <= imem_data_i;
            id_pc_o     <= imem_addr_o;
            id_valid_o  <= 1'b1;
            pc          <= imem_addr_o + 1'b1;
            imem_addr_o <= imem_addr_o + 1'b1;
          end else if (ack) begin
            skid_inst  <= imem_data_i;
            skid_pc    <= imem_addr_o;
            pc         <= imem_addr_o + 1'b1;
            imem_req_o <= 1'b0;
            state      <= HOLD;
          end else if (id_valid_o && !stall_i) begin
            id_valid_o <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            id_inst_o   <= skid_inst;
            id_pc_o     <= skid_pc;
            id_valid_o  <= 1'b1;
            skid_pc     <= '0;
            skid_inst   <= '0;
            imem_req_o  <= 1'b1;
            imem_addr_o <= pc;
            state       <= FETCH;
          end
        end
        default: begin
          if (ack) begin
            pc          <= redir;
            imem_addr_o <= redir;
            state       <= FETCH;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors for if_fetch, including a wrap-around instance at RESET_PC=FFFF
module tb_if_fetch;
  logic        clk, rst, stall, branch, ack_en;
  logic [15:0] target;
  logic        req0, req1, val0, val1;
  logic [15:0] addr0, addr1, pc0, pc1, inst0, inst1;
  int          n_chk = 0, n_fail = 0;

  if_fetch #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'h0000)) u0 (
    .clk(clk), .rst(rst), .imem_req_o(req0), .imem_addr_o(addr0),
    .imem_ack_i(ack_en), .imem_data_i(addr0 ^ 16'hA5A5),
    .stall_i(stall), .branch_i(branch), .branch_target_i(target),
    .id_valid_o(val0), .id_pc_o(pc0), .id_inst_o(inst0));

  if_fetch #(.ADDR_W(16), .INST_W(16), .RESET_PC(16'hFFFF)) u1 (
    .clk(clk), .rst(rst), .imem_req_o(req1), .imem_addr_o(addr1),
    .imem_ack_i(1'b1), .imem_data_i(addr1 ^ 16'hA5A5),
    .stall_i(1'b0), .branch_i(1'b0), .branch_target_i(16'h0000),
    .id_valid_o(val1), .id_pc_o(pc1), .id_inst_o(inst1));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 0; stall = 0; branch = 0; ack_en = 0; target = 0;
    repeat (2) @(negedge clk);
    chk("rst_req", req0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_valid", val0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_inst", inst0, 0);
    rst = 1; ack_en = 1;
    step();
    chk("e1_req", req0, 1);
    chk("e1_addr", addr0, 16'h0000);
    chk("e1_valid", val0, 0);
    chk("w1_addr", addr1, 16'hFFFF);
    step();
    chk("e2_addr", addr0, 16'h0001);
    chk("e2_valid", val0, 1);
    chk("e2_pc", pc0, 16'h0000);
    chk("e2_inst", inst0, 16'hA5A5);
    chk("w2_addr", addr1, 16'h0000);
    chk("w2_pc", pc1, 16'hFFFF);
    chk("w2_inst", inst1, 16'h5A5A);
    step();
    chk("e3_addr", addr0, 16'h0002);
    chk("e3_pc", pc0, 16'h0001);
    chk("e3_inst", inst0, 16'hA5A4);
    chk("w3_addr", addr1, 16'h0001);
    chk("w3_pc", pc1, 16'h0000);
    step();
    chk("e4_addr", addr0, 16'h0003);
    chk("e4_pc", pc0, 16'h0002);
    chk("e4_inst", inst0, 16'hA5A7);
    chk("e4_valid", val0, 1);
    chk("w4_pc", pc1, 16'h0001);
    stall = 1;
    step();
    chk("hold_req", req0, 0);
    chk("hold_pc", pc0, 16'h0002);
    chk("hold_valid", val0, 1);
    step();
    step();
    chk("hold3_req", req0, 0);
    chk("hold3_pc", pc0, 16'h0002);
    chk("hold3_inst", inst0, 16'hA5A7);
    stall = 0;
    step();
    chk("rel_pc", pc0, 16'h0003);
    chk("rel_inst", inst0, 16'hA5A6);
    chk("rel_valid", val0, 1);
    chk("rel_req", req0, 1);
    chk("rel_addr", addr0, 16'h0004);
    step();
    chk("a4_pc", pc0, 16'h0004);
    chk("a4_addr", addr0, 16'h0005);
    ack_en = 0; branch = 1; target = 16'h0040;
    step();
    branch = 0;
    chk("drain_valid", val0, 0);
    chk("drain_req", req0, 1);
    chk("drain_addr", addr0, 16'h0005);
    step();
    chk("drain2_valid", val0, 0);
    chk("drain2_addr", addr0, 16'h0005);
    ack_en = 1;
    step();
    chk("redir_valid", val0, 0);
    chk("redir_addr", addr0, 16'h0040);
    chk("redir_req", req0, 1);
    step();
    chk("t40_pc", pc0, 16'h0040);
    chk("t40_inst", inst0, 16'hA5E5);
    chk("t40_valid", val0, 1);
    chk("t40_addr", addr0, 16'h0041);
    stall = 1; branch = 1; target = 16'h0100;
    step();
    stall = 0; branch = 0;
    chk("bas_valid", val0, 0);
    chk("bas_addr", addr0, 16'h0100);
    chk("bas_req", req0, 1);
    step();
    chk("b100_pc", pc0, 16'h0100);
    chk("b100_valid", val0, 1);
    chk("b100_inst", inst0, 16'h0100 ^ 16'hA5A5);
    chk("b100_addr", addr0, 16'h0101);
    #2 rst = 0;
    #1;
    chk("arst_req", req0, 0);
    chk("arst_valid", val0, 0);
    chk("arst_pc", pc0, 0);
    chk("arst_inst", inst0, 0);
    chk("arst_addr", addr0, 0);
    @(negedge clk);
    rst = 1;
    step();
    chk("rs_addr", addr0, 16'h0000);
    chk("rs_req", req0, 1);
    chk("rs_valid", val0, 0);
    step();
    chk("rs_pc", pc0, 16'h0000);
    chk("rs_inst", inst0, 16'hA5A5);
    chk("rs_w_pc", pc1, 16'hFFFF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch front end of the pipeline; the opposite end from the ID/EX → EX → MEM → WB path.
- Holds the PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Delivers fetched instruction and its PC to ID through a registered output stage with valid/stall.
- Handles ID back-pressure with a one-entry skid buffer, and branch redirects with flush and discard of in-flight data.

Parameters:
ADDR_W, 16, instruction address / PC width (word-addressed)
INST_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
imem_req_o  out  1  fetch request to instruction memory
imem_addr_o  out  ADDR_W  fetch address; stable while imem_req_o=1
imem_ack_i  in  1  memory ack; data valid this cycle; sampled only when imem_req_o=1
imem_data_i  in  INST_W  instruction data, valid with imem_ack_i
stall_i  in  1  ID cannot accept a new instruction this cycle
branch_i  in  1  redirect pulse from ID/EX
branch_target_i  in  ADDR_W  redirect target, valid with branch_i
id_valid_o  out  1  id_inst_o/id_pc_o hold a live instruction
id_pc_o  out  ADDR_W  PC of presented instruction
id_inst_o  out  INST_W  presented instruction

Behaviour:
- Reset (rst=0, async, no clock needed): state IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0 (NOP), skid empty, redirect register cleared. Outstanding request is abandoned; memory must tolerate req dropping.
- All outputs are registered.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: first edge after rst deasserts → FETCH, with imem_req_o=1 and imem_addr_o=pc.
- FETCH, request rules:
  - Once raised, imem_req_o stays high with constant address until the ack edge.
  - Ack may arrive in the same cycle req is first high, or any later cycle.
- FETCH, on ack with no branch:
  - If the output slot is free (id_valid_o=0, or stall_i=0 this cycle): id_inst_o←data, id_pc_o←imem_addr_o, id_valid_o←1, pc←pc+1, imem_addr_o←pc+1, req stays 1. Throughput is 1 instruction/cycle.
  - If the slot is occupied and stall_i=1: data and address go to the skid buffer, pc←pc+1, imem_req_o←0 → HOLD.
- FETCH, no ack: if id_valid_o=1 and stall_i=0, id_valid_o←0.
- HOLD: imem_req_o=0; outputs frozen while stall_i=1. When stall_i=0, the skid moves to the outputs (id_valid_o=1), skid cleared, imem_req_o←1 at pc → FETCH.
- Branch (branch_i=1 at the edge) has priority over stall and ack. id_valid_o←0 and skid cleared in every state.
  - Request outstanding and no ack this cycle: save target in the redirect register, keep req/addr unchanged → DRAIN.
  - Ack in the same cycle, or no request outstanding (HOLD/IDLE after reset): discard any data, pc←target, imem_addr_o←target, imem_req_o←1 → FETCH.
- DRAIN: hold the old request until ack; the acked data is discarded (never reaches id_*). On ack: pc←redirect, new request at redirect → FETCH.
  - A further branch_i in DRAIN overwrites the redirect register (last branch wins).
- stall_i never alters an in-flight request; it only gates output updates.
- PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W−1 increments to 0.
- Invariants:
  - At most one outstanding request.
  - No instruction is presented twice, skipped, or reordered (except instructions flushed by a branch).
  - id_pc_o+1 equals the PC of the next presented instruction unless a branch intervened.

Test Plan:
- Reset with RESET_PC=0 and memory acking every cycle (data=addr^16'hA5A5) → imem_addr_o 0,1,2,3 on consecutive cycles; id_pc_o 0,1,2 with id_inst_o A5A5,A5A4,A5A7; id_valid_o=1 continuously.
- stall_i=1 for 3 cycles while id_valid_o=1 (pc 2 presented) and ack of addr 3 lands → HOLD, imem_req_o=0, id_pc_o stays 2; on stall release id_pc_o=3, then req resumes at addr 4.
- Request to addr 5 outstanding, ack delayed 3 cycles, branch_i with target 16'h0040 in cycle 1 → id_valid_o=0 next cycle, addr 5 held until ack, its data never appears; next request at 16'h0040, id_pc_o=0040 after its ack.
- branch_i, imem_ack_i and stall_i=1 all in one cycle, target 16'h0100 → id_valid_o=0, skid empty, next imem_addr_o=0100, no DRAIN.
- RESET_PC=16'hFFFF, ack every cycle → addresses FFFF, 0000, 0001; id_pc_o wraps identically.
- rst driven low mid-request between clock edges → imem_req_o, id_valid_o, id_pc_o, id_inst_o go to 0 immediately; after release, fetch restarts at RESET_PC.
